axis_distributor: RTL and testbench

- Inverse of the flag-driven AXIS selector: one data stream plus one 1-bit flag stream in, two data streams out.
- Each data word is joined with one flag word. Flag 0 routes the word to output_0; flag 1 routes it to output_1.
- Used where a merged stream is split back into its two lanes, e.g. after a selector on the decompression side.
- Each output has a one-entry register stage. Per-output transfer counters are provided for status and debug.

---
 rtl/lcplc_axis_pkg.sv | 12 +
 rtl/axis_output_stage.sv | 38 +++
 rtl/axis_distributor.sv | 106 ++++++++++
 tb/tb_axis_distributor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcplc_axis_pkg.sv
// Shared constants for the lcplc AXIS stream utilities.
package lcplc_axis_pkg;

   // Flag values that select the destination lane.
   localparam logic SEL_PORT_0 = 1'b0;
   localparam logic SEL_PORT_1 = 1'b1;

   // Default widths used by the stream utilities.
   localparam int unsigned DEFAULT_DATA_WIDTH    = 16;
   localparam int unsigned DEFAULT_COUNTER_WIDTH = 32;

endpackage

// File: rtl/axis_output_stage.sv
// One-entry AXIS register stage: a load port on the upstream side and a
// standard valid/ready interface on the downstream side.
module axis_output_stage
   import lcplc_axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] load_data_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;

   // Hold one word; a load in the same cycle as an unload keeps the stage full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
         end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/axis_distributor.sv
// Splits one AXIS data stream into two lanes, steered word-by-word by a
// companion 1-bit flag stream. Each lane has a one-entry output stage and
// a transfer counter.
module axis_distributor
   import lcplc_axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     input_valid,
   output logic                     input_ready,
   input  logic [DATA_WIDTH-1:0]    input_data,
   input  logic                     flag_valid,
   output logic                     flag_ready,
   input  logic                     flag_data,
   output logic                     output_0_valid,
   input  logic                     output_0_ready,
   output logic [DATA_WIDTH-1:0]    output_0_data,
   output logic                     output_1_valid,
   input  logic                     output_1_ready,
   output logic [DATA_WIDTH-1:0]    output_1_data,
   output logic [COUNTER_WIDTH-1:0] count_0,
   output logic [COUNTER_WIDTH-1:0] count_1
);

   logic                     can_accept_0;
   logic                     can_accept_1;
   logic                     sel_can_accept;
   logic                     fire;
   logic                     load_0;
   logic                     load_1;
   logic                     hs_0;
   logic                     hs_1;
   logic [COUNTER_WIDTH-1:0] count_0_q, count_0_d;
   logic [COUNTER_WIDTH-1:0] count_1_q, count_1_d;

   // Join and routing: data and flag are consumed together, only when the
   // selected lane can take the word. Readys are held low during reset.
   always_comb begin
      can_accept_0   = !output_0_valid || output_0_ready;
      can_accept_1   = !output_1_valid || output_1_ready;
      sel_can_accept = (flag_data == SEL_PORT_1) ? can_accept_1 : can_accept_0;
      input_ready    = !rst && flag_valid && sel_can_accept;
      flag_ready     = !rst && input_valid && sel_can_accept;
      fire           = !rst && input_valid && flag_valid && sel_can_accept;
      load_0         = fire && (flag_data == SEL_PORT_0);
      load_1         = fire && (flag_data == SEL_PORT_1);
   end

   axis_output_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_stage_0 (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load_0),
      .load_data_i (input_data),
      .valid_o     (output_0_valid),
      .ready_i     (output_0_ready),
      .data_o      (output_0_data)
   );

   axis_output_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_stage_1 (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load_1),
      .load_data_i (input_data),
      .valid_o     (output_1_valid),
      .ready_i     (output_1_ready),
      .data_o      (output_1_data)
   );

   // Next counter values: clear takes priority over a coincident handshake.
   always_comb begin
      hs_0      = output_0_valid && output_0_ready;
      hs_1      = output_1_valid && output_1_ready;
      count_0_d = count_0_q;
      count_1_d = count_1_q;
      if (clear) begin
         count_0_d = '0;
         count_1_d = '0;
      end else begin
         if (hs_0) count_0_d = count_0_q + 1'b1;
         if (hs_1) count_1_d = count_1_q + 1'b1;
      end
   end

   // Per-lane transfer counters, wrapping at 2^COUNTER_WIDTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_0_q <= '0;
         count_1_q <= '0;
      end else begin
         count_0_q <= count_0_d;
         count_1_q <= count_1_d;
      end
   end

   assign count_0 = count_0_q;
   assign count_1 = count_1_q;

endmodule

// File: tb/tb_axis_distributor.sv
// Directed bench for axis_distributor with hand-computed expectations.
module tb_axis_distributor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        input_valid = 1'b0;
   logic        input_ready;
   logic [15:0] input_data = '0;
   logic        flag_valid = 1'b0;
   logic        flag_ready;
   logic        flag_data = 1'b0;
   logic        output_0_valid;
   logic        output_0_ready = 1'b0;
   logic [15:0] output_0_data;
   logic        output_1_valid;
   logic        output_1_ready = 1'b0;
   logic [15:0] output_1_data;
   logic [31:0] count_0;
   logic [31:0] count_1;

   int checks = 0;
   int errors = 0;

   axis_distributor #(
      .DATA_WIDTH    (16),
      .COUNTER_WIDTH (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .clear          (clear),
      .input_valid    (input_valid),
      .input_ready    (input_ready),
      .input_data     (input_data),
      .flag_valid     (flag_valid),
      .flag_ready     (flag_ready),
      .flag_data      (flag_data),
      .output_0_valid (output_0_valid),
      .output_0_ready (output_0_ready),
      .output_0_data  (output_0_data),
      .output_1_valid (output_1_valid),
      .output_1_ready (output_1_ready),
      .output_1_data  (output_1_data),
      .count_0        (count_0),
      .count_1        (count_1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic fv, input logic [15:0] d, input logic f);
      input_valid = iv;
      flag_valid  = fv;
      input_data  = d;
      flag_data   = f;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'd0, 1'b0);
   endtask

   // Offer one joined word that must be accepted this cycle, then check it
   // appears on its lane one cycle later.
   task automatic push(input logic [15:0] d, input logic f, input string tag);
      drive(1'b1, 1'b1, d, f);
      #1;
      check({tag, " in_rdy"}, {31'd0, input_ready}, 32'd1);
      check({tag, " flag_rdy"}, {31'd0, flag_ready}, 32'd1);
      tick();
      check({tag, " out_valid"}, {31'd0, (f ? output_1_valid : output_0_valid)}, 32'd1);
      check({tag, " out_data"}, {16'd0, (f ? output_1_data : output_0_data)}, {16'd0, d});
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state, with valids offered to confirm readys are forced low
      drive(1'b1, 1'b1, 16'h1234, 1'b0);
      output_0_ready = 1'b1;
      output_1_ready = 1'b1;
      tick();
      #1;
      check("rst in_rdy", {31'd0, input_ready}, 32'd0);
      check("rst flag_rdy", {31'd0, flag_ready}, 32'd0);
      check("rst o0v", {31'd0, output_0_valid}, 32'd0);
      check("rst o1v", {31'd0, output_1_valid}, 32'd0);
      check("rst o0d", {16'd0, output_0_data}, 32'd0);
      check("rst c0", count_0, 32'd0);
      check("rst c1", count_1, 32'd0);
      idle();
      rst = 1'b0;
      tick();

      // T1: alternating lanes, both drains ready
      push(16'd512, 1'b0, "t1a");
      push(16'd513, 1'b1, "t1b");
      check("t1b o0v", {31'd0, output_0_valid}, 32'd0);
      check("t1b c0", count_0, 32'd1);
      push(16'd514, 1'b0, "t1c");
      check("t1c o1v", {31'd0, output_1_valid}, 32'd0);
      check("t1c c1", count_1, 32'd1);
      push(16'd515, 1'b1, "t1d");
      check("t1d o0v", {31'd0, output_0_valid}, 32'd0);
      check("t1d c0", count_0, 32'd2);
      idle();
      tick();
      check("t1 o1v", {31'd0, output_1_valid}, 32'd0);
      check("t1 c0", count_0, 32'd2);
      check("t1 c1", count_1, 32'd2);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr c0", count_0, 32'd0);
      check("clr c1", count_1, 32'd0);

      // T2: lane 1 stalled, head-of-line blocking on a flag-1 word
      output_1_ready = 1'b0;
      push(16'd512, 1'b0, "t2a");
      push(16'd513, 1'b1, "t2b");
      check("t2b o0v", {31'd0, output_0_valid}, 32'd0);
      check("t2b c0", count_0, 32'd1);
      drive(1'b1, 1'b1, 16'd514, 1'b1);
      for (int i = 0; i < 8; i++) begin
         #1;
         check("t2 stall in_rdy", {31'd0, input_ready}, 32'd0);
         check("t2 stall flag_rdy", {31'd0, flag_ready}, 32'd0);
         tick();
         check("t2 stall o1v", {31'd0, output_1_valid}, 32'd1);
         check("t2 stall o1d", {16'd0, output_1_data}, 32'd513);
         check("t2 stall c1", count_1, 32'd0);
      end
      output_1_ready = 1'b1;
      #1;
      check("t2 resume in_rdy", {31'd0, input_ready}, 32'd1);
      tick();
      check("t2 resume o1v", {31'd0, output_1_valid}, 32'd1);
      check("t2 resume o1d", {16'd0, output_1_data}, 32'd514);
      check("t2 resume c1", count_1, 32'd1);
      push(16'd515, 1'b0, "t2d");
      check("t2d o1v", {31'd0, output_1_valid}, 32'd0);
      check("t2d c1", count_1, 32'd2);
      idle();
      tick();
      check("t2 c0", count_0, 32'd2);
      check("t2 o0v", {31'd0, output_0_valid}, 32'd0);

      // T3: data without flag does not transfer
      drive(1'b1, 1'b0, 16'd600, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t3 in_rdy", {31'd0, input_ready}, 32'd0);
         check("t3 flag_rdy", {31'd0, flag_ready}, 32'd1);
         tick();
         check("t3 o0v", {31'd0, output_0_valid}, 32'd0);
         check("t3 c0", count_0, 32'd2);
      end
      flag_valid = 1'b1;
      #1;
      check("t3 go in_rdy", {31'd0, input_ready}, 32'd1);
      tick();
      check("t3 go o0v", {31'd0, output_0_valid}, 32'd1);
      check("t3 go o0d", {16'd0, output_0_data}, 32'd600);
      idle();
      tick();
      check("t3 c0 end", count_0, 32'd3);

      // T4: lane 0 saturated back-to-back
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 8; i++) push(16'(1000 + i), 1'b0, "t4");
      idle();
      tick();
      check("t4 c0", count_0, 32'd8);

      // T5: clear coincides with an output_0 handshake
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 6; i++) push(16'(1100 + i), 1'b0, "t5");
      check("t5 c0 pre", count_0, 32'd5);
      idle();
      clear = 1'b1;
      #1;
      check("t5 hs o0v", {31'd0, output_0_valid}, 32'd1);
      check("t5 hs o0d", {16'd0, output_0_data}, 32'd1105);
      tick();
      clear = 1'b0;
      check("t5 c0 clr", count_0, 32'd0);
      check("t5 o0v", {31'd0, output_0_valid}, 32'd0);
      tick();
      check("t5 c0 hold", count_0, 32'd0);

      // T6: asynchronous reset with both stages full
      push(16'd1200, 1'b1, "t6a");
      idle();
      tick();
      check("t6 c1 pre", count_1, 32'd1);
      output_0_ready = 1'b0;
      output_1_ready = 1'b0;
      push(16'd1201, 1'b0, "t6b");
      push(16'd1202, 1'b1, "t6c");
      check("t6 both o0v", {31'd0, output_0_valid}, 32'd1);
      drive(1'b1, 1'b1, 16'd1203, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("t6 rst o0v", {31'd0, output_0_valid}, 32'd0);
      check("t6 rst o1v", {31'd0, output_1_valid}, 32'd0);
      check("t6 rst c1", count_1, 32'd0);
      check("t6 rst in_rdy", {31'd0, input_ready}, 32'd0);
      check("t6 rst flag_rdy", {31'd0, flag_ready}, 32'd0);
      tick();
      check("t6 rst2 in_rdy", {31'd0, input_ready}, 32'd0);
      check("t6 rst2 o0v", {31'd0, output_0_valid}, 32'd0);
      idle();
      #2;
      rst = 1'b0;
      output_0_ready = 1'b1;
      output_1_ready = 1'b1;
      push(16'd1300, 1'b0, "t6d");
      check("t6d c0", count_0, 32'd0);
      idle();
      tick();
      check("t6 c0 end", count_0, 32'd1);
      check("t6 c1 end", count_1, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
